lut_logic_eval: RTL and testbench

- Parametrised, registered successor to the fixed-gate logic cells.
- Evaluates CH independent K-input boolean functions every cycle; each function is held as a 2^K-entry truth table.
- Tables reset to INIT. INIT defaults to F(A,B,C) = A' + BC.
- A serial config port reprograms any one channel's table at run time through a shadow register and an atomic commit, so evaluation never sees a partial table.

---
 rtl/lut_logic_eval_if.sv | 30 +++
 rtl/lut_logic_eval.sv | 132 +++++++++++++
 tb/tb_lut_logic_eval.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/lut_logic_eval_if.sv
// Bus bundle for lut_logic_eval: evaluation operands/results and the serial config port.
// The DUT attaches through the slave modport; the driver side uses master.
interface lut_logic_eval_if #(
   parameter int K  = 3,
   parameter int CH = 2
);
   localparam int CW = (CH > 1) ? $clog2(CH) : 1;

   logic              in_valid;
   logic [CH*K-1:0]   in_vec;
   logic              out_valid;
   logic [CH-1:0]     out_f;
   logic              cfg_start;
   logic [CW-1:0]     cfg_ch;
   logic              cfg_bit_valid;
   logic              cfg_bit;
   logic              cfg_busy;
   logic              cfg_done;
   logic              cfg_err;

   modport master (
      output in_valid, in_vec, cfg_start, cfg_ch, cfg_bit_valid, cfg_bit,
      input  out_valid, out_f, cfg_busy, cfg_done, cfg_err
   );

   modport slave (
      input  in_valid, in_vec, cfg_start, cfg_ch, cfg_bit_valid, cfg_bit,
      output out_valid, out_f, cfg_busy, cfg_done, cfg_err
   );
endinterface

// File: rtl/lut_logic_eval.sv
// CH independent K-input registered LUTs with a serial, shadow-buffered table loader.
// A new table is only written in the single COMMIT cycle, so lookups never see a partial table.
module lut_logic_eval #(
   parameter int                  K    = 3,
   parameter int                  CH   = 2,
   parameter logic [(2**K)-1:0]   INIT = 8'h8F
) (
   input logic              clk,
   input logic              rst,
   lut_logic_eval_if.slave  bus
);
   localparam int N  = 2**K;
   localparam int CW = (CH > 1) ? $clog2(CH) : 1;
   localparam logic [CW:0] CH_LIM   = (CW+1)'(CH);
   localparam logic [K:0]  CNT_LAST = (K+1)'(N-1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [K:0]      cnt_q, cnt_d;
   logic [N-1:0]    shadow_q, shadow_d;
   logic [CW-1:0]   ch_q, ch_d;
   logic            cfg_err_q, cfg_err_d;
   logic            out_valid_q, out_valid_d;
   logic [CH-1:0]   out_f_q, out_f_d;
   logic            ch_ok;

   assign ch_ok = ({1'b0, bus.cfg_ch} < CH_LIM);

   // ---------------- config FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         shadow_q  <= '0;
         ch_q      <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         ch_q      <= ch_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shadow_d  = shadow_q;
      ch_d      = ch_q;
      cfg_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cfg_start) begin
               if (ch_ok) begin
                  ch_d     = bus.cfg_ch;
                  cnt_d    = '0;
                  shadow_d = '0;
                  state_d  = SHIFT;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         SHIFT: begin
            // cfg_start is deliberately ignored here: a load cannot be restarted
            if (bus.cfg_bit_valid) begin
               shadow_d[cnt_q[K-1:0]] = bus.cfg_bit;
               cnt_d                  = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = COMMIT;
               end
            end
         end
         COMMIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------- per-channel tables and lookup ----------------
   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_ch
         logic [N-1:0] tbl_q, tbl_d;

         always_comb begin
            tbl_d = tbl_q;
            if (state_q == COMMIT && ch_q == CW'(gi)) begin
               tbl_d = shadow_q;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               tbl_q <= INIT;
            end else begin
               tbl_q <= tbl_d;
            end
         end

         // Lookup reads tbl_q, so a sample taken during COMMIT still sees the old table
         assign out_f_d[gi] = bus.in_valid ? tbl_q[bus.in_vec[gi*K +: K]] : out_f_q[gi];
      end
   endgenerate

   assign out_valid_d = bus.in_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_f_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_f_q     <= out_f_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_f     = out_f_q;
   assign bus.cfg_busy  = (state_q != IDLE);
   assign bus.cfg_done  = (state_q == COMMIT);
   assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_lut_logic_eval.sv
// Self-checking bench for lut_logic_eval: directed scenarios plus random traffic,
// all checked against a table-level reference model.
module tb_lut_logic_eval;
   localparam int K  = 3;
   localparam int CH = 2;
   localparam int N  = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lut_logic_eval_if #(.K(K), .CH(CH)) bus ();
   lut_logic_eval #(.K(K), .CH(CH), .INIT(8'h8F)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Three-channel instance: the only way to present an out-of-range cfg_ch
   lut_logic_eval_if #(.K(K), .CH(3)) bus3 ();
   lut_logic_eval #(.K(K), .CH(3), .INIT(8'h8F)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: tables as bit arrays, a pending load as a queue of received bits
   logic [N-1:0] m_tbl [CH];
   logic [CH-1:0] m_f;
   bit            m_loading;
   bit            m_commit;
   int            m_ch;
   bit            m_bits [$];

   task automatic model_reset();
      logic [2:0] v;
      for (int c = 0; c < CH; c++) begin
         for (int i = 0; i < N; i++) begin
            v = i[2:0];
            m_tbl[c][i] = ~v[2] | (v[1] & v[0]);   // A' + BC
         end
      end
      m_f       = '0;
      m_loading = 1'b0;
      m_commit  = 1'b0;
      m_ch      = 0;
      m_bits.delete();
   endtask

   // Drive one cycle on the main DUT, predict, clock, compare
   task automatic cycle(input bit iv, input logic [CH*K-1:0] vec, input bit cs, input int cch,
                        input bit cbv, input bit cb);
      logic [CH-1:0] ef;
      bit            eerr;
      bus.in_valid      = iv;
      bus.in_vec        = vec;
      bus.cfg_start     = cs;
      bus.cfg_ch        = 1'(cch);
      bus.cfg_bit_valid = cbv;
      bus.cfg_bit       = cb;

      ef = m_f;
      if (iv) begin
         for (int c = 0; c < CH; c++) ef[c] = m_tbl[c][vec[c*K +: K]];
      end
      eerr = !(m_loading || m_commit) && cs && (cch >= CH);
      if (m_commit) begin
         for (int i = 0; i < N; i++) m_tbl[m_ch][i] = m_bits[i];
         m_commit = 1'b0;
      end else if (m_loading) begin
         if (cbv) begin
            m_bits.push_back(cb);
            if (m_bits.size() == N) begin
               m_loading = 1'b0;
               m_commit  = 1'b1;
            end
         end
      end else if (cs && cch < CH) begin
         m_loading = 1'b1;
         m_ch      = cch;
         m_bits.delete();
      end
      m_f = ef;

      @(posedge clk);
      #1;
      check("out_valid", bus.out_valid, iv);
      check("out_f",     bus.out_f,     ef);
      check("cfg_busy",  bus.cfg_busy,  m_loading || m_commit);
      check("cfg_done",  bus.cfg_done,  m_commit);
      check("cfg_err",   bus.cfg_err,   eerr);
   endtask

   task automatic idle_cycle();
      cycle(1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] and3;
      int         nbit;
      and3 = 8'h80;

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_vec = '0; bus.cfg_start = 1'b0;
      bus.cfg_ch = '0; bus.cfg_bit_valid = 1'b0; bus.cfg_bit = 1'b0;
      bus3.in_valid = 1'b0; bus3.in_vec = '0; bus3.cfg_start = 1'b0;
      bus3.cfg_ch = '0; bus3.cfg_bit_valid = 1'b0; bus3.cfg_bit = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_f",     bus.out_f,     0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy",      bus.cfg_busy,  0);
      check("rst_done",      bus.cfg_done,  0);
      check("rst_err",       bus.cfg_err,   0);
      rst = 1'b0;

      // Default function on both channels
      cycle(1'b1, {3'b100, 3'b000}, 1'b0, 0, 1'b0, 1'b0);
      check("tp1_a", bus.out_f, 2'b01);
      cycle(1'b1, {3'b111, 3'b110}, 1'b0, 0, 1'b0, 1'b0);
      check("tp1_b", bus.out_f, 2'b10);

      // Exhaustive ch0 with hold gaps
      for (int i = 0; i < N; i++) begin
         cycle(1'b1, {3'b000, 3'(i)}, 1'b0, 0, 1'b0, 1'b0);
         if (i % 3 == 2) idle_cycle();
      end

      // Load AND3 into ch1 while evaluating ch1=011 every cycle
      cycle(1'b1, {3'b011, 3'b000}, 1'b1, 1, 1'b0, 1'b0);
      check("tp3_busy", bus.cfg_busy, 1);
      nbit = 0;
      while (nbit < N) begin
         if (nbit == 3 || nbit == 6) begin
            cycle(1'b1, {3'b011, 3'b000}, 1'b0, 0, 1'b0, 1'b1);
         end
         cycle(1'b1, {3'b011, 3'b000}, 1'b1, 0, 1'b1, and3[nbit]);
         nbit++;
      end
      check("tp3_done", bus.cfg_done, 1);
      cycle(1'b1, {3'b011, 3'b000}, 1'b0, 0, 1'b0, 1'b0);
      check("tp4_old", bus.out_f[1], 1);
      cycle(1'b1, {3'b011, 3'b000}, 1'b0, 0, 1'b0, 1'b0);
      check("tp4_new", bus.out_f[1], 0);
      cycle(1'b1, {3'b111, 3'b000}, 1'b0, 0, 1'b0, 1'b0);
      check("tp3_and3", bus.out_f, 2'b11);

      // Out-of-range channel on the 3-channel instance
      bus3.cfg_start = 1'b1;
      bus3.cfg_ch    = 2'd3;
      idle_cycle();
      bus3.cfg_start = 1'b0;
      check("tp5_err",  bus3.cfg_err,  1);
      check("tp5_busy", bus3.cfg_busy, 0);
      bus3.in_valid = 1'b1;
      bus3.in_vec   = {3'b011, 3'b100, 3'b000};
      idle_cycle();
      bus3.in_valid = 1'b0;
      check("tp5_err_end", bus3.cfg_err, 0);
      check("tp5_tbl",     bus3.out_f,   3'b101);

      // Reset in the middle of a load
      cycle(1'b1, {3'b011, 3'b000}, 1'b1, 1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, {3'b011, 3'b000}, 1'b0, 0, 1'b1, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("tp6_busy",  bus.cfg_busy,  0);
      check("tp6_out_f", bus.out_f,     0);
      check("tp6_valid", bus.out_valid, 0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      cycle(1'b1, {3'b011, 3'b000}, 1'b0, 0, 1'b0, 1'b0);
      check("tp6_init", bus.out_f[1], 1);
      for (int i = 0; i < 10; i++) idle_cycle();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(0, 1)), (CH*K)'($urandom),
               ($urandom_range(0, 7) == 0), int'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
